// File: rtl/calc_pkg.sv
// Shared constants, encodings and state type for the calculator entry sequencer.
package calc_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned REGI_W = 2;
    localparam int unsigned DISP_W = 2;
    localparam int unsigned DIG_W  = 3;

    localparam int unsigned MAX_DIGITS_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;
    localparam int unsigned CNT_W_DEF      = 7;

    localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [KEY_W-1:0] KEY_ADD       = 4'd10;
    localparam logic [KEY_W-1:0] KEY_SUB       = 4'd11;
    localparam logic [KEY_W-1:0] KEY_EQ        = 4'd14;
    localparam logic [KEY_W-1:0] KEY_CLR       = 4'd15;

    localparam logic [REGI_W-1:0] SEL_HOLD = 2'd0;
    localparam logic [REGI_W-1:0] SEL_A    = 2'd1;
    localparam logic [REGI_W-1:0] SEL_B    = 2'd2;
    localparam logic [REGI_W-1:0] SEL_OP   = 2'd3;

    localparam logic [DISP_W-1:0] DISP_A   = 2'd0;
    localparam logic [DISP_W-1:0] DISP_B   = 2'd1;
    localparam logic [DISP_W-1:0] DISP_RES = 2'd2;
    localparam logic [DISP_W-1:0] DISP_ERR = 2'd3;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTER_B = 3'd2,
        EXEC    = 3'd3,
        RESULT  = 3'd4,
        ERROR   = 3'd5
    } state_t;

endpackage

// File: rtl/calc_entry_ctrl_key_class.sv
// Combinational key decoder: classifies a key code as digit, operator, '=' or 'C'.
module calc_key_class
    import calc_pkg::*;
(
    input  logic [KEY_W-1:0] key_code,
    output logic             is_digit,
    output logic             is_op,
    output logic             is_eq,
    output logic             is_clr
);

    always_comb begin
        is_digit = (key_code <= KEY_DIGIT_MAX);
        is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
        is_eq    = (key_code == KEY_EQ);
        is_clr   = (key_code == KEY_CLR);
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad sequencer: routes digits/operator into the datapath, launches the ALU
// and selects what the display shows.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    input  logic              alu_done,
    output logic [REGI_W-1:0] regi,
    output logic [KEY_W-1:0]  nr_out,
    output logic              clr,
    output logic              alu_start,
    output logic [DISP_W-1:0] disp_sel,
    output logic [DIG_W-1:0]  digits,
    output logic              err
);

    logic is_digit;
    logic is_op;
    logic is_eq;
    logic is_clr;

    calc_key_class u_key_class (
        .key_code (key_code),
        .is_digit (is_digit),
        .is_op    (is_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr)
    );

    state_t             state, state_n;
    logic [REGI_W-1:0]  regi_n;
    logic [KEY_W-1:0]   nr_n;
    logic               clr_n;
    logic               start_n;
    logic [DISP_W-1:0]  disp_n;
    logic [DIG_W-1:0]   digits_n;
    logic               err_n;
    logic [CNT_W-1:0]   tcnt, tcnt_n;
    logic               pend, pend_n;
    logic [KEY_W-1:0]   pdig, pdig_n;

    logic dig_key;
    logic op_key;
    logic eq_key;
    logic room;

    assign dig_key = key_valid && is_digit;
    assign op_key  = key_valid && is_op;
    assign eq_key  = key_valid && is_eq;
    assign room    = (digits < DIG_W'(MAX_DIGITS));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ENTER_A;
            regi      <= SEL_HOLD;
            nr_out    <= '0;
            clr       <= 1'b0;
            alu_start <= 1'b0;
            disp_sel  <= DISP_A;
            digits    <= '0;
            err       <= 1'b0;
            tcnt      <= '0;
            pend      <= 1'b0;
            pdig      <= '0;
        end else begin
            state     <= state_n;
            regi      <= regi_n;
            nr_out    <= nr_n;
            clr       <= clr_n;
            alu_start <= start_n;
            disp_sel  <= disp_n;
            digits    <= digits_n;
            err       <= err_n;
            tcnt      <= tcnt_n;
            pend      <= pend_n;
            pdig      <= pdig_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        regi_n   = SEL_HOLD;
        nr_n     = nr_out;
        clr_n    = 1'b0;
        start_n  = 1'b0;
        disp_n   = disp_sel;
        digits_n = digits;
        err_n    = err;
        tcnt_n   = tcnt;
        pend_n   = pend;
        pdig_n   = pdig;

        if (key_valid && is_clr) begin
            clr_n    = 1'b1;
            state_n  = ENTER_A;
            digits_n = '0;
            disp_n   = DISP_A;
            err_n    = 1'b0;
            pend_n   = 1'b0;
            tcnt_n   = '0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (dig_key && room) begin
                        regi_n   = SEL_A;
                        nr_n     = key_code;
                        digits_n = digits + DIG_W'(1);
                    end else if (op_key) begin
                        regi_n   = SEL_OP;
                        nr_n     = key_code;
                        digits_n = '0;
                        disp_n   = DISP_B;
                        state_n  = OP_WAIT;
                    end
                end
                OP_WAIT: begin
                    if (op_key) begin
                        regi_n = SEL_OP;
                        nr_n   = key_code;
                    end else if (dig_key) begin
                        regi_n   = SEL_B;
                        nr_n     = key_code;
                        digits_n = DIG_W'(1);
                        state_n  = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (dig_key && room) begin
                        regi_n   = SEL_B;
                        nr_n     = key_code;
                        digits_n = digits + DIG_W'(1);
                    end else if (eq_key) begin
                        start_n = 1'b1;
                        tcnt_n  = '0;
                        state_n = EXEC;
                    end
                end
                EXEC: begin
                    // alu_start is high only in the entry cycle, so it masks alu_done there
                    if (!alu_start && alu_done) begin
                        disp_n  = DISP_RES;
                        state_n = RESULT;
                    end else if (tcnt == CNT_W'(TIMEOUT)) begin
                        err_n   = 1'b1;
                        disp_n  = DISP_ERR;
                        state_n = ERROR;
                    end else begin
                        tcnt_n = tcnt + CNT_W'(1);
                    end
                end
                RESULT: begin
                    // A digit here clears the datapath first, then loads it a cycle later
                    if (pend) begin
                        regi_n   = SEL_A;
                        nr_n     = pdig;
                        digits_n = DIG_W'(1);
                        pend_n   = 1'b0;
                        state_n  = ENTER_A;
                    end else if (dig_key) begin
                        clr_n    = 1'b1;
                        pend_n   = 1'b1;
                        pdig_n   = key_code;
                        digits_n = '0;
                        disp_n   = DISP_A;
                    end
                end
                ERROR: begin
                end
                default: begin
                    state_n = ENTER_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed self-checking bench for calc_entry_ctrl.
module tb_calc_entry_ctrl;

    localparam int unsigned TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       alu_done;
    logic [1:0] regi;
    logic [3:0] nr_out;
    logic       clr;
    logic       alu_start;
    logic [1:0] disp_sel;
    logic [2:0] digits;
    logic       err;

    int n_checks = 0;
    int n_err    = 0;

    calc_entry_ctrl #(
        .MAX_DIGITS (4),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .alu_done  (alu_done),
        .regi      (regi),
        .nr_out    (nr_out),
        .clr       (clr),
        .alu_start (alu_start),
        .disp_sel  (disp_sel),
        .digits    (digits),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key is presented for one cycle; on return the bench sits in cycle N+1
    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_regi"},  32'(regi), 0);
        chk({tag, "_nr"},    32'(nr_out), 0);
        chk({tag, "_clr"},   32'(clr), 0);
        chk({tag, "_start"}, 32'(alu_start), 0);
        chk({tag, "_disp"},  32'(disp_sel), 0);
        chk({tag, "_dig"},   32'(digits), 0);
        chk({tag, "_err"},   32'(err), 0);
    endtask

    initial begin
        int cyc;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        alu_done  = 1'b0;
        repeat (3) tick();
        chk_reset_outs("rst");
        reset = 1'b0;

        // Operand 1 entry: 1,2,3
        press(4'd1);
        chk("a1_regi", 32'(regi), 1);
        chk("a1_nr", 32'(nr_out), 1);
        tick();
        chk("a1_hold_regi", 32'(regi), 0);
        chk("a1_hold_nr", 32'(nr_out), 1);
        press(4'd2);
        chk("a2_nr", 32'(nr_out), 2);
        press(4'd3);
        chk("a3_regi", 32'(regi), 1);
        chk("a3_nr", 32'(nr_out), 3);
        chk("a3_dig", 32'(digits), 3);
        chk("a3_disp", 32'(disp_sel), 0);
        press(4'd12);
        chk("k12_regi", 32'(regi), 0);
        chk("k12_dig", 32'(digits), 3);

        // Clear, then digit limit
        press(4'd15);
        chk("c_clr", 32'(clr), 1);
        chk("c_regi", 32'(regi), 0);
        chk("c_dig", 32'(digits), 0);
        tick();
        chk("c_clr_off", 32'(clr), 0);
        for (int i = 1; i <= 4; i++) begin
            press(4'(i));
            chk("lim_regi", 32'(regi), 1);
            chk("lim_nr", 32'(nr_out), 32'(i));
        end
        press(4'd5);
        chk("lim5_regi", 32'(regi), 0);
        chk("lim5_dig", 32'(digits), 4);

        // 7 + - 9 = with alu_done three cycles after launch
        press(4'd15);
        press(4'd7);
        chk("e7_regi", 32'(regi), 1);
        press(4'd10);
        chk("eadd_regi", 32'(regi), 3);
        chk("eadd_nr", 32'(nr_out), 10);
        chk("eadd_dig", 32'(digits), 0);
        chk("eadd_disp", 32'(disp_sel), 1);
        press(4'd11);
        chk("esub_regi", 32'(regi), 3);
        chk("esub_nr", 32'(nr_out), 11);
        press(4'd9);
        chk("e9_regi", 32'(regi), 2);
        chk("e9_nr", 32'(nr_out), 9);
        chk("e9_dig", 32'(digits), 1);
        press(4'd14);
        chk("eq_start", 32'(alu_start), 1);
        chk("eq_regi", 32'(regi), 0);
        tick();
        chk("eq_start_off", 32'(alu_start), 0);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("res_disp", 32'(disp_sel), 2);
        chk("res_start", 32'(alu_start), 0);

        // RESULT + digit: clear then load
        press(4'd8);
        chk("r8_clr", 32'(clr), 1);
        chk("r8_regi", 32'(regi), 0);
        tick();
        chk("r8_load_regi", 32'(regi), 1);
        chk("r8_load_nr", 32'(nr_out), 8);
        chk("r8_load_dig", 32'(digits), 1);
        chk("r8_load_clr", 32'(clr), 0);
        chk("r8_load_disp", 32'(disp_sel), 0);

        // Back to RESULT, then 'C' in N+1 cancels the pending digit
        press(4'd10);
        press(4'd3);
        press(4'd14);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("res2_disp", 32'(disp_sel), 2);
        press(4'd8);
        chk("rc_clr1", 32'(clr), 1);
        press(4'd15);
        chk("rc_clr2", 32'(clr), 1);
        chk("rc_regi", 32'(regi), 0);
        tick();
        chk("rc_no_load", 32'(regi), 0);
        chk("rc_dig", 32'(digits), 0);

        // Timeout: alu_done in the entry cycle is ignored, then never arrives
        press(4'd10);
        press(4'd1);
        press(4'd14);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("to_entry_disp", 32'(disp_sel), 1);
        chk("to_entry_err", 32'(err), 0);
        cyc = 0;
        while (!err && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("to_err", 32'(err), 1);
        chk("to_window", 32'(cyc >= TIMEOUT - 2 && cyc <= TIMEOUT + 2), 1);
        chk("to_disp", 32'(disp_sel), 3);
        press(4'd5);
        chk("err5_regi", 32'(regi), 0);
        chk("err5_err", 32'(err), 1);
        press(4'd15);
        chk("errc_clr", 32'(clr), 1);
        chk("errc_err", 32'(err), 0);
        chk("errc_disp", 32'(disp_sel), 0);

        // Reset during EXEC
        press(4'd10);
        press(4'd2);
        press(4'd14);
        tick();
        reset = 1'b1;
        tick();
        chk_reset_outs("mrst");
        reset = 1'b0;
        alu_done = 1'b1;
        tick();
        tick();
        alu_done = 1'b0;
        chk("mrst_done_disp", 32'(disp_sel), 0);
        chk("mrst_done_err", 32'(err), 0);
        press(4'd4);
        chk("mrst_a_regi", 32'(regi), 1);
        chk("mrst_a_nr", 32'(nr_out), 4);
        chk("mrst_a_dig", 32'(digits), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
